// File: rtl/lights_pkg.sv
// Types and timing defaults shared by the push-button conditioner and the
// colour-sequencing stage of the traffic-light demo.
package lights_pkg;

  typedef enum logic [1:0] {
    LT_IDLE   = 2'd0,
    LT_HOLD   = 2'd1,
    LT_REPEAT = 2'd2
  } btn_state_e;

  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam int DEF_HOLD_CYCLES     = 8;
  localparam int DEF_REPEAT_CYCLES   = 3;
  localparam int DEF_COUNT_W         = 8;

  // Bits needed to count 0..n-1, never fewer than one.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// Signal bundle between the board-side button logic and its conditioner.
interface button_conditioner_if
  import lights_pkg::*;
#(
  parameter int COUNT_W = DEF_COUNT_W
) ();

  logic               button_raw;
  logic               repeat_en;
  logic               press;
  logic               level;
  logic               held;
  logic [COUNT_W-1:0] press_count;

  modport master (
    output button_raw, repeat_en,
    input  press, level, held, press_count
  );

  modport slave (
    input  button_raw, repeat_en,
    output press, level, held, press_count
  );

endinterface

// File: rtl/debouncer.sv
// Two-flop synchroniser plus consecutive-sample debounce; o_rise/o_fall flag
// the edge at which the registered level is about to flip.
module debouncer
  import lights_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_raw,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  localparam int               CNT_W    = clog2_min1(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_s1;
  logic             r_s2;
  logic             r_level;
  logic [CNT_W-1:0] r_cnt;
  logic             w_differ;
  logic             w_flip;

  assign w_differ = (r_s2 != r_level);
  assign w_flip   = w_differ && (r_cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_level <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_s1 <= i_raw;
      r_s2 <= r_s1;
      if (!w_differ) begin
        r_cnt <= '0;
      end else if (!w_flip) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end else begin
        r_level <= r_s2;
        r_cnt   <= '0;
      end
    end
  end

  assign o_level = r_level;
  assign o_rise  = w_flip && r_s2;
  assign o_fall  = w_flip && !r_s2;

endmodule

// File: rtl/button_conditioner.sv
// Turns the raw button pin into single-cycle press strobes with optional
// auto-repeat while held, plus a wrapping press counter for debug.
module button_conditioner
  import lights_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES,
  parameter int COUNT_W         = DEF_COUNT_W
) (
  input logic                 clk,
  input logic                 rst_n,
  button_conditioner_if.slave bus
);

  localparam int                TICK_W    = clog2_min1(max_int(HOLD_CYCLES, REPEAT_CYCLES));
  localparam logic [TICK_W-1:0] HOLD_LAST = TICK_W'(HOLD_CYCLES - 1);
  localparam logic [TICK_W-1:0] REP_LAST  = TICK_W'(REPEAT_CYCLES - 1);

  localparam logic [1:0] ST_IDLE   = LT_IDLE;
  localparam logic [1:0] ST_HOLD   = LT_HOLD;
  localparam logic [1:0] ST_REPEAT = LT_REPEAT;

  logic               w_level;
  logic               w_rise;
  logic               w_fall;
  logic [1:0]         r_state;
  logic [1:0]         w_state_next;
  logic [TICK_W-1:0]  r_tick;
  logic [TICK_W-1:0]  w_tick_next;
  logic               r_press;
  logic               w_press_next;
  logic               r_held;
  logic [COUNT_W-1:0] r_press_count;

  debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_raw  (bus.button_raw),
    .o_level(w_level),
    .o_rise (w_rise),
    .o_fall (w_fall)
  );

  // A debounced fall is tested first in every held state so it beats a tick expiry.
  always_comb begin
    w_state_next = r_state;
    w_tick_next  = r_tick;
    w_press_next = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_rise) begin
          w_state_next = ST_HOLD;
          w_tick_next  = '0;
          w_press_next = 1'b1;
        end
      end
      ST_HOLD: begin
        if (w_fall) begin
          w_state_next = ST_IDLE;
        end else if (bus.repeat_en && (r_tick >= HOLD_LAST)) begin
          w_state_next = ST_REPEAT;
          w_tick_next  = '0;
          w_press_next = 1'b1;
        end else if (r_tick < HOLD_LAST) begin
          w_tick_next = r_tick + TICK_W'(1);
        end
      end
      ST_REPEAT: begin
        if (w_fall) begin
          w_state_next = ST_IDLE;
        end else if (!bus.repeat_en) begin
          w_state_next = ST_HOLD;
        end else if (r_tick >= REP_LAST) begin
          w_tick_next  = '0;
          w_press_next = 1'b1;
        end else begin
          w_tick_next = r_tick + TICK_W'(1);
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_tick_next  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_tick        <= '0;
      r_press       <= 1'b0;
      r_held        <= 1'b0;
      r_press_count <= '0;
    end else begin
      r_state <= w_state_next;
      r_tick  <= w_tick_next;
      r_press <= w_press_next;
      r_held  <= (w_state_next == ST_REPEAT);
      if (w_press_next) begin
        r_press_count <= r_press_count + COUNT_W'(1);
      end
    end
  end

  assign bus.press       = r_press;
  assign bus.level       = w_level;
  assign bus.held        = r_held;
  assign bus.press_count = r_press_count;

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench: directed timing scenarios plus randomized bounce/hold
// traffic, compared every edge against a window-based reference model.
module tb_button_conditioner;
  import lights_pkg::*;

  localparam int D    = 4;
  localparam int HOLD = 8;
  localparam int REP  = 3;
  localparam int CW   = 2;
  localparam int MAXE = 16384;

  logic clk = 1'b0;
  logic rst_n;

  button_conditioner_if #(.COUNT_W(CW)) bus ();

  button_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .HOLD_CYCLES    (HOLD),
    .REPEAT_CYCLES  (REP),
    .COUNT_W        (CW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int edge_n   = 0;
  int last_rst = 0;
  bit raw_hist [MAXE];

  bit m_level  = 1'b0;
  bit m_active = 1'b0;
  bit m_press  = 1'b0;
  bit m_held   = 1'b0;
  int m_start  = 0;
  int m_count  = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: edge %0d got %0d expected %0d", tag, edge_n, got, exp);
    end
  endtask

  // Synchronised sample seen by the debouncer at edge m (zero until the pipe refills after reset).
  function automatic bit s2_at(input int m);
    if (m - 2 >= last_rst + 1) return raw_hist[m-2];
    return 1'b0;
  endfunction

  // Level flips when the last D post-reset samples all disagree with it.
  function automatic bit window_flip(input int n);
    for (int j = 0; j < D; j++) begin
      if (n - j < last_rst + 1) return 1'b0;
      if (s2_at(n - j) == m_level) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_edge(input bit ren, input bit rn);
    if (!rn) begin
      last_rst = edge_n;
      m_level  = 1'b0;
      m_active = 1'b0;
      m_press  = 1'b0;
      m_held   = 1'b0;
      m_count  = 0;
      return;
    end
    m_press = 1'b0;
    if (window_flip(edge_n)) begin
      m_level = !m_level;
      if (m_level) begin
        m_active = 1'b1;
        m_start  = edge_n;
        m_press  = 1'b1;
      end else begin
        m_active = 1'b0;
      end
    end else if (m_active && ren && (edge_n >= m_start + HOLD) &&
                 ((edge_n - m_start - HOLD) % REP == 0)) begin
      m_press = 1'b1;
    end
    m_held = m_active && ren && (edge_n >= m_start + HOLD);
    if (m_press) m_count = (m_count + 1) % (1 << CW);
  endtask

  task automatic step(input bit raw, input bit ren, input bit rn);
    @(negedge clk);
    bus.button_raw = raw;
    bus.repeat_en  = ren;
    rst_n          = rn;
    @(posedge clk);
    #1;
    edge_n++;
    if (edge_n >= MAXE) begin
      $display("FAIL edge_budget: edge %0d got over expected %0d", edge_n, MAXE);
      $fatal(1, "edge budget exhausted");
    end
    raw_hist[edge_n] = raw;
    model_edge(ren, rn);
    check_eq("press", int'(bus.press), int'(m_press));
    check_eq("level", int'(bus.level), int'(m_level));
    check_eq("held", int'(bus.held), int'(m_held));
    check_eq("count", int'(bus.press_count), m_count);
  endtask

  function automatic logic [63:0] rmask(input int lo, input int hi);
    logic [63:0] m;
    m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  // Directed run: reset at rel 0 (and optionally rst_rel), raw high for rel edges [hi_from, hi_to).
  task automatic run_directed(input int id, input bit ren, input int hi_from, input int hi_to,
                              input int rst_rel, input logic [63:0] press_m,
                              input logic [63:0] level_m, input logic [63:0] held_m,
                              input int final_count);
    int npress;
    npress = 0;
    for (int rel = 0; rel <= 60; rel++) begin
      step((rel >= hi_from) && (rel < hi_to), ren, !((rel == 0) || (rel == rst_rel)));
      check_eq($sformatf("s%0d_press", id), int'(bus.press), int'(press_m[rel]));
      check_eq($sformatf("s%0d_level", id), int'(bus.level), int'(level_m[rel]));
      check_eq($sformatf("s%0d_held", id), int'(bus.held), int'(held_m[rel]));
      if (rel == rst_rel) check_eq($sformatf("s%0d_rst_count", id), int'(bus.press_count), 0);
      if (bus.press) npress++;
    end
    check_eq($sformatf("s%0d_final_count", id), int'(bus.press_count), final_count);
    $display("scenario %0d: repeat_en=%0d presses=%0d press_count=%0d", id, ren, npress, bus.press_count);
  endtask

  initial begin
    logic [63:0] p4;
    logic [63:0] p5;
    bit ren;
    bus.button_raw = 1'b0;
    bus.repeat_en  = 1'b0;
    rst_n          = 1'b0;

    // Clean press, glitch, auto-repeat, reset inside REPEAT.
    run_directed(1, 1'b0, 10, 31, -1, rmask(15, 15), rmask(15, 35), '0, 1);
    run_directed(3, 1'b0, 10, 13, -1, '0, '0, '0, 0);
    p4 = '0;
    for (int k = 0; k < 9; k++) p4[(k == 0) ? 15 : 23 + 3 * (k - 1)] = 1'b1;
    run_directed(4, 1'b1, 10, 40, -1, p4, rmask(15, 44), rmask(23, 44), 1);
    p5 = '0;
    p5[15] = 1'b1; p5[23] = 1'b1; p5[31] = 1'b1; p5[39] = 1'b1; p5[42] = 1'b1;
    run_directed(5, 1'b1, 10, 40, 25, p5, rmask(15, 24) | rmask(31, 44),
                 rmask(23, 24) | rmask(39, 44), 3);

    // Counter wrap: five clean presses on a 2-bit counter.
    step(1'b0, 1'b0, 1'b0);
    for (int p = 0; p < 5; p++) begin
      for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 1'b1);
      check_eq("wrap_count", int'(bus.press_count), (p + 1) % 4);
      for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 1'b1);
      $display("wrap press %0d: press_count=%0d", p + 1, bus.press_count);
    end

    // Randomized bounce / hold / release segments, occasional reset.
    ren = 1'b0;
    for (int seg = 0; seg < 80; seg++) begin
      int nb;
      int nh;
      int rst_at;
      int start_cnt;
      start_cnt = m_count;
      if (!m_active) ren = 1'($urandom % 2);
      nb = $urandom_range(0, 8);
      for (int i = 0; i < nb; i++) step(1'($urandom % 2), ren, 1'b1);
      nh = $urandom_range(0, 40);
      rst_at = (($urandom % 8) == 0) ? $urandom_range(0, nh) : -1;
      for (int i = 0; i < nh; i++) step(1'b1, ren, i != rst_at);
      nb = $urandom_range(0, 8);
      for (int i = 0; i < nb; i++) step(1'($urandom % 2), ren, 1'b1);
      for (int i = 0; i < 12; i++) step(1'b0, ren, 1'b1);
      $display("segment %0d: repeat_en=%0d hold=%0d reset=%0d count %0d->%0d",
               seg, ren, nh, rst_at, start_cnt, bus.press_count);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
